// File: rtl/bip_pkg.sv
// ----------------------------------------------------------------------------
// bip_pkg
// Shared constants and encodings for the BIP execution datapath.
//   - Width constants for the accumulator/RAM word, the control OPERAND,
//     the data RAM address and the retired-cycle counter.
//   - Accumulator source select encodings (SEL_A).
//   - ALU operation encodings (OP).
//   - sign_ext(): widens an OPERAND immediate to a datapath word.
// ----------------------------------------------------------------------------
package bip_pkg;

    localparam int DATA_W = 16;
    localparam int OPND_W = 11;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 32;

    typedef enum logic [1:0] {
        SRC_RAM  = 2'd0,
        SRC_IMM  = 2'd1,
        SRC_ALU  = 2'd2,
        SRC_HOLD = 2'd3
    } src_sel_e;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    // Replicates the OPERAND sign bit into the upper word bits.
    function automatic logic [DATA_W-1:0] sign_ext(input logic [OPND_W-1:0] v);
        return {{(DATA_W-OPND_W){v[OPND_W-1]}}, v};
    endfunction

endpackage

// File: rtl/bip_datapath_if.sv
// ----------------------------------------------------------------------------
// bip_datapath_if
// Bundles the control-unit strobes and the datapath status outputs.
//   master : control side - drives SEL_A, SEL_B, WR_ACC, OP, WR_RAM, RD_RAM,
//            OPERAND; observes ACC, ZERO, OVF, CYCLES.
//   slave  : datapath side - the mirror image.
// ----------------------------------------------------------------------------
interface bip_datapath_if #(
    parameter int DATA_W = bip_pkg::DATA_W,
    parameter int OPND_W = bip_pkg::OPND_W,
    parameter int CNT_W  = bip_pkg::CNT_W
);

    logic [1:0]        SEL_A;
    logic              SEL_B;
    logic              WR_ACC;
    logic              OP;
    logic              WR_RAM;
    logic              RD_RAM;
    logic [OPND_W-1:0] OPERAND;

    logic [DATA_W-1:0] ACC;
    logic              ZERO;
    logic              OVF;
    logic [CNT_W-1:0]  CYCLES;

    modport master (
        output SEL_A, SEL_B, WR_ACC, OP, WR_RAM, RD_RAM, OPERAND,
        input  ACC, ZERO, OVF, CYCLES
    );

    modport slave (
        input  SEL_A, SEL_B, WR_ACC, OP, WR_RAM, RD_RAM, OPERAND,
        output ACC, ZERO, OVF, CYCLES
    );

endinterface

// File: rtl/bip_data_ram.sv
// ----------------------------------------------------------------------------
// bip_data_ram
// Data RAM of the BIP datapath: 2^ADDR_W words of DATA_W bits.
//   clk   in  : write clock, rising edge
//   we    in  : write enable, mem[addr] <= wdata at the edge
//   re    in  : read enable; rdata is forced to zero when low
//   addr  in  : shared read/write address
//   wdata in  : write data
//   rdata out : combinational read data (old contents during a write)
// ----------------------------------------------------------------------------
module bip_data_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array carries no reset so it maps onto RAM macros; software
    // must write a location before it is meaningful to read it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = re ? mem[addr] : '0;

endmodule

// File: rtl/bip_datapath.sv
// ----------------------------------------------------------------------------
// bip_datapath
// BIP execution datapath: accumulator, sign extension, add/sub ALU, data RAM,
// sticky signed-overflow flag and a free-running retired-cycle counter.
//   CLK   in  : system clock, rising edge
//   RESET in  : synchronous active-high reset
//   bus   slave modport of bip_datapath_if:
//     SEL_A, SEL_B, WR_ACC, OP, WR_RAM, RD_RAM, OPERAND  (from control)
//     ACC, ZERO, OVF, CYCLES                             (status out)
// One instruction retires per clock; results appear on ACC after one edge.
// ----------------------------------------------------------------------------
module bip_datapath #(
    parameter int DATA_W = bip_pkg::DATA_W,
    parameter int OPND_W = bip_pkg::OPND_W,
    parameter int ADDR_W = bip_pkg::ADDR_W,
    parameter int CNT_W  = bip_pkg::CNT_W
) (
    input  logic          CLK,
    input  logic          RESET,
    bip_datapath_if.slave bus
);

    import bip_pkg::*;

    logic [DATA_W-1:0] acc_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  cycles_q;

    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] res;
    logic              ovf_now;
    logic [DATA_W-1:0] acc_next;

    assign imm  = sign_ext(bus.OPERAND);
    // Upper OPERAND bits are dropped, so addresses wrap modulo the RAM depth.
    assign addr = bus.OPERAND[ADDR_W-1:0];

    // A RAM write in the reset cycle is suppressed; the old ACC is stored.
    bip_data_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (CLK),
        .we    (bus.WR_RAM & ~RESET),
        .re    (bus.RD_RAM),
        .addr  (addr),
        .wdata (acc_q),
        .rdata (rdata)
    );

    assign op_b = bus.SEL_B ? imm : rdata;

    // Signed overflow: for add, both operands share a sign the result lacks;
    // for sub, operands differ in sign and the result flips away from ACC.
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no latch can be inferred.
    always_comb begin
        res     = '0;
        ovf_now = 1'b0;
        if (alu_op_e'(bus.OP) == ALU_SUB) begin
            res     = acc_q - op_b;
            ovf_now = (acc_q[DATA_W-1] != op_b[DATA_W-1]) &&
                      (res[DATA_W-1]   != acc_q[DATA_W-1]);
        end else begin
            res     = acc_q + op_b;
            ovf_now = (acc_q[DATA_W-1] == op_b[DATA_W-1]) &&
                      (res[DATA_W-1]   != acc_q[DATA_W-1]);
        end
    end

    always_comb begin
        acc_next = acc_q;
        case (src_sel_e'(bus.SEL_A))
            SRC_RAM:  acc_next = rdata;
            SRC_IMM:  acc_next = imm;
            SRC_ALU:  acc_next = res;
            SRC_HOLD: acc_next = acc_q;
            default:  acc_next = acc_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values (the RAM store sees the old ACC).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_q + 1'b1;
            if (bus.WR_ACC) begin
                acc_q <= acc_next;
            end
            if (bus.WR_ACC && (src_sel_e'(bus.SEL_A) == SRC_ALU) && ovf_now) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.ACC    = acc_q;
    assign bus.ZERO   = (acc_q == '0);
    assign bus.OVF    = ovf_q;
    assign bus.CYCLES = cycles_q;

endmodule

// File: tb/tb_bip_datapath.sv
// ----------------------------------------------------------------------------
// tb_bip_datapath
// Self-checking bench for bip_datapath: directed vector table, hand-written
// corner sequences and randomized instructions against a reference model.
// ----------------------------------------------------------------------------
module tb_bip_datapath;

    logic clk;
    logic rst;

    bip_datapath_if bus ();

    bip_datapath dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [15:0] m_acc;
    logic        m_ovf;
    logic [31:0] m_cycles;
    logic [15:0] m_mem   [1024];
    bit          m_valid [1024];

    typedef struct {
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        wr_acc;
        logic        op;
        logic        wr_ram;
        logic        rd_ram;
        logic [10:0] opnd;
        logic [15:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Applies one instruction, lets it retire, advances the model and
    // compares every output against it.
    task automatic cyc(input logic r, input logic [1:0] sa, input logic sb,
                       input logic wa, input logic op, input logic wr,
                       input logic rd, input logic [10:0] opnd);
        int          imm_s;
        int          a_s;
        int          b_s;
        int          r_s;
        logic [15:0] imm;
        logic [15:0] rdata;
        logic [15:0] opb;
        logic [15:0] src;
        int          addr;
        rst         = r;
        bus.SEL_A   = sa;
        bus.SEL_B   = sb;
        bus.WR_ACC  = wa;
        bus.OP      = op;
        bus.WR_RAM  = wr;
        bus.RD_RAM  = rd;
        bus.OPERAND = opnd;
        @(posedge clk);
        #1;
        imm_s = (int'(opnd) >= 1024) ? int'(opnd) - 2048 : int'(opnd);
        imm   = imm_s[15:0];
        addr  = int'(opnd) % 1024;
        rdata = rd ? m_mem[addr] : 16'h0000;
        opb   = sb ? imm : rdata;
        a_s   = int'($signed(m_acc));
        b_s   = int'($signed(opb));
        r_s   = op ? a_s - b_s : a_s + b_s;
        case (sa)
            2'd0:    src = rdata;
            2'd1:    src = imm;
            2'd2:    src = r_s[15:0];
            default: src = m_acc;
        endcase
        if (r) begin
            m_acc    = 16'h0000;
            m_ovf    = 1'b0;
            m_cycles = 32'd0;
        end else begin
            if (wr) begin
                m_mem[addr]   = m_acc;
                m_valid[addr] = 1'b1;
            end
            if (wa && sa == 2'd2 && (r_s > 32767 || r_s < -32768)) m_ovf = 1'b1;
            if (wa) m_acc = src;
            m_cycles = m_cycles + 32'd1;
        end
        check("model_acc",    32'(bus.ACC),  32'(m_acc));
        check("model_ovf",    32'(bus.OVF),  32'(m_ovf));
        check("model_zero",   32'(bus.ZERO), 32'(m_acc == 16'h0000));
        check("model_cycles", bus.CYCLES,    m_cycles);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        logic [10:0] ro;
        logic [1:0]  rs;
        logic        rrd;

        m_acc    = '0;
        m_ovf    = 1'b0;
        m_cycles = '0;
        for (int i = 0; i < 1024; i++) begin
            m_mem[i]   = '0;
            m_valid[i] = 1'b0;
        end

        // Reset state.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_acc",    32'(bus.ACC),  32'h0);
        check("reset_zero",   32'(bus.ZERO), 32'h1);
        check("reset_ovf",    32'(bus.OVF),  32'h0);
        check("reset_cycles", bus.CYCLES,    32'h0);

        // Directed vectors: load/store, sign extension, add/sub immediate.
        tbl[0] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF, 16'hFFFF, 1'b0};
        tbl[1] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h003, 16'hFFFF, 1'b0};
        tbl[2] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0};
        tbl[3] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h003, 16'hFFFF, 1'b0};
        tbl[4] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h010, 16'h0010, 1'b0};
        tbl[5] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h005, 16'h0015, 1'b0};
        tbl[6] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h7FF, 16'h0016, 1'b0};
        tbl[7] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h3FF, 16'h03FF, 1'b0};
        tbl[8] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h400, 16'hFC00, 1'b0};
        for (int i = 0; i < 9; i++) begin
            cyc(0, tbl[i].sel_a, tbl[i].sel_b, tbl[i].wr_acc, tbl[i].op,
                tbl[i].wr_ram, tbl[i].rd_ram, tbl[i].opnd);
            check($sformatf("vec%0d_acc", i), 32'(bus.ACC), 32'(tbl[i].exp_acc));
            check($sformatf("vec%0d_ovf", i), 32'(bus.OVF), 32'(tbl[i].exp_ovf));
        end

        // Build 0x7FFF, then overflow on +1; OVF stays set afterwards.
        cyc(0, 1, 0, 1, 0, 0, 0, 11'h3FF);
        for (int i = 0; i < 31; i++) cyc(0, 2, 1, 1, 0, 0, 0, 11'h3FF);
        cyc(0, 2, 1, 1, 0, 0, 0, 11'h01F);
        check("pre_ovf_acc", 32'(bus.ACC), 32'h7FFF);
        check("pre_ovf_flag", 32'(bus.OVF), 32'h0);
        cyc(0, 2, 1, 1, 0, 0, 0, 11'h001);
        check("ovf_acc", 32'(bus.ACC), 32'h8000);
        check("ovf_flag", 32'(bus.OVF), 32'h1);
        cyc(0, 2, 1, 1, 1, 0, 0, 11'h001);
        check("ovf_sub_acc", 32'(bus.ACC), 32'h7FFF);
        check("ovf_sticky", 32'(bus.OVF), 32'h1);

        // Build 0xAAAA, then simultaneous store and load, then address wrap.
        cyc(0, 2, 1, 1, 0, 0, 0, 11'h001);
        for (int i = 0; i < 10; i++) cyc(0, 2, 1, 1, 0, 0, 0, 11'h3FF);
        cyc(0, 2, 1, 1, 0, 0, 0, 11'h2B4);
        check("build_aaaa", 32'(bus.ACC), 32'hAAAA);
        cyc(0, 1, 0, 1, 0, 1, 0, 11'h009);
        check("st_ld_acc", 32'(bus.ACC), 32'h0009);
        cyc(0, 0, 0, 1, 0, 0, 1, 11'h409);
        check("wrap_read", 32'(bus.ACC), 32'hAAAA);

        // Read-during-write: old contents now, new contents next cycle.
        cyc(0, 0, 0, 1, 0, 1, 1, 11'h003);
        check("rdw_old", 32'(bus.ACC), 32'hFFFF);
        cyc(0, 0, 0, 1, 0, 0, 1, 11'h003);
        check("rdw_new", 32'(bus.ACC), 32'hAAAA);

        // Hold with SEL_A=ALU but WR_ACC low; then gated read loads zero.
        c0 = int'(m_cycles);
        for (int i = 0; i < 4; i++) cyc(0, 2, 1, 0, 0, 0, 0, 11'h001);
        check("hold_acc", 32'(bus.ACC), 32'hAAAA);
        check("hold_cycles", bus.CYCLES, 32'(c0 + 4));
        cyc(0, 0, 0, 1, 0, 0, 0, 11'h005);
        check("gated_rd_acc", 32'(bus.ACC), 32'h0000);
        check("gated_rd_zero", 32'(bus.ZERO), 32'h1);

        // Reset mid-operation with a RAM write that must be suppressed.
        cyc(0, 1, 0, 1, 0, 0, 0, 11'h055);
        cyc(0, 3, 0, 0, 0, 1, 0, 11'h005);
        cyc(0, 1, 0, 1, 0, 0, 0, 11'h3FF);
        for (int i = 0; i < 3; i++) cyc(0, 2, 1, 1, 0, 0, 0, 11'h3FF);
        cyc(0, 2, 1, 1, 0, 0, 0, 11'h238);
        check("pre_rst_acc", 32'(bus.ACC), 32'h1234);
        cyc(1, 1, 0, 1, 0, 1, 0, 11'h005);
        check("mid_rst_acc", 32'(bus.ACC), 32'h0);
        check("mid_rst_zero", 32'(bus.ZERO), 32'h1);
        check("mid_rst_ovf", 32'(bus.OVF), 32'h0);
        check("mid_rst_cycles", bus.CYCLES, 32'h0);
        cyc(0, 0, 0, 1, 0, 0, 1, 11'h005);
        check("mem5_kept", 32'(bus.ACC), 32'h0055);

        // Randomized instructions; reads only from locations already written.
        for (int n = 0; n < 600; n++) begin
            ro  = 11'($urandom_range(0, 2047));
            rs  = 2'($urandom_range(0, 3));
            rrd = 1'($urandom_range(0, 1)) && m_valid[int'(ro) % 1024];
            if (n % 8 == 0) begin
                ro  = 11'(int'(ro[9:0]) % 16);
                rrd = m_valid[int'(ro)];
            end
            cyc(($urandom_range(0, 49) == 0), rs, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) == 0), rrd, ro);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
